fetch_unit: RTL

Instruction fetch stage of the single-cycle NAND CPU. Holds the program counter and issues one instruction-memory request at a time. Buffers the returned instruction for the decoder on a valid/ready handshake. Redirects on taken branches using the predicate (`ps`) and target (`rt`) values produced by the register file. Sits between instruction memory and the decoder; it is the consumer of the regfile's fetch-side outputs.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and widths for the NAND CPU fetch stage.
// Imported by the fetch unit and by its output interface.
package fetch_unit_pkg;

    localparam int unsigned INST_W = 16;
    localparam int unsigned ADDR_W = 16;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StFull,
        StHalted
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decoder handshake.
// Carries the buffered instruction and its PC on a valid/ready pair.
interface fetch_output_ifc
    import fetch_unit_pkg::*;
();

    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    modport fetch_unit (
        output inst_valid,
        output inst_data,
        output inst_pc,
        input  inst_ready
    );

    modport decoder (
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Holds the PC, issues one imem request at a time, buffers one instruction and handles redirect/halt.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,

    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,

    fetch_output_ifc.fetch_unit fetch_out,

    input  logic              br_valid,
    input  logic              br_ps,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt,
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
    logic              squash_q, squash_d;
    logic              halt_pend_q, halt_pend_d;
    logic [INST_W-1:0] inst_data_q, inst_data_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

    logic              halting;
    logic              redirect;
    logic              req_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StReq;
            pc_q        <= RESET_PC;
            buf_pc_q    <= '0;
            squash_q    <= 1'b0;
            halt_pend_q <= 1'b0;
            inst_data_q <= '0;
            inst_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_pc_q    <= buf_pc_d;
            squash_q    <= squash_d;
            halt_pend_q <= halt_pend_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_pc_d    = buf_pc_q;
        squash_d    = squash_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;

        halt_pend_d = halt_pend_q | halt;
        halting     = halt_pend_d;
        // Halt outranks redirect, including in the cycle halt first appears.
        redirect    = br_valid & br_ps & ~halting;
        req_fire    = imem_req_valid & imem_req_ready;

        unique case (state_q)
            StReq: begin
                if (req_fire) begin
                    buf_pc_d = pc_q;
                    pc_d     = redirect ? br_target : pc_q + ADDR_W'(1);
                    squash_d = redirect;
                    state_d  = StWait;
                end else if (halting) begin
                    state_d = StHalted;
                end else if (redirect) begin
                    pc_d = br_target;
                end
            end

            StWait: begin
                if (imem_rsp_valid) begin
                    squash_d = 1'b0;
                    if (halting) begin
                        state_d = StHalted;
                    end else if (squash_q || redirect) begin
                        state_d = StReq;
                    end else begin
                        inst_data_d = imem_rsp_data;
                        inst_pc_d   = buf_pc_q;
                        state_d     = StFull;
                    end
                    if (redirect) begin
                        pc_d = br_target;
                    end
                end else if (redirect) begin
                    pc_d     = br_target;
                    squash_d = 1'b1;
                end
            end

            StFull: begin
                if (halting) begin
                    if (fetch_out.inst_ready) begin
                        state_d = StHalted;
                    end
                end else if (redirect) begin
                    // Buffered instruction is dropped even if accepted this cycle.
                    pc_d    = br_target;
                    state_d = StReq;
                end else if (fetch_out.inst_ready) begin
                    state_d = StReq;
                end
            end

            StHalted: begin
                state_d = StHalted;
            end

            default: begin
                state_d = StReq;
            end
        endcase
    end

    assign imem_req_valid       = (state_q == StReq) & ~halt_pend_q & ~rst;
    assign imem_req_addr        = pc_q;
    assign fetch_out.inst_valid = (state_q == StFull);
    assign fetch_out.inst_data  = inst_data_q;
    assign fetch_out.inst_pc    = inst_pc_q;
    assign halted               = (state_q == StHalted);

endmodule
